rr_arbiter8: RTL and testbench
==============================

// Module: rr_arbiter8
// PURPOSE
//  8-way round-robin arbiter sharing one resource between 8 requesters.
//  Winner index is registered, then expanded to a one-hot grant vector with the
//  team's 3-to-8 decoder mapping: gnt[i] is high iff gnt_idx == i.
//  Sits in front of any single-ported shared unit (bus, register port, ALU).
//  Optional hold limit prevents one requester from starving the others.
// PARAMETERS
//  MAX_HOLD  16  max consecutive cycles one grant is held; 0 = unlimited
//  CNT_W     5   hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      async active-low reset
//  req        in   [0:7]  request, req[i] from requester i; level, held until served
//  gnt        out  [0:7]  one-hot grant, registered; all-zero when none
//  gnt_idx    out  [0:2]  index of granted requester, gnt_idx[0] = MSB
//  gnt_valid  out  1      high iff exactly one gnt bit is high
// BEHAVIOUR
//  Reset (rst_n low, async): gnt=0, gnt_idx=0, gnt_valid=0, ptr=0, hold_cnt=0,
//  state=IDLE. All outputs register-driven; no comb path from req to gnt.
//  Pointer ptr [0:2]: search start. Winner = first i with req[i]=1, scanning
//  ptr, ptr+1, ... ptr+7 (mod 8). On every new grant to w: ptr <= w+1 (7 wraps to 0).
//  FSM, 2 states:
//   IDLE : no req -> stay. Any req -> GRANT; winner registered at that edge.
//          Latency: req rises in cycle N -> gnt/gnt_valid high in cycle N+1.
//   GRANT: hold_cnt increments each cycle grant is held; cleared on new grant.
//    - req[gnt_idx]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD-1): hold.
//    - release: req[gnt_idx]=0. Same edge: if any other req pending, grant next
//      winner from ptr (zero-bubble handoff); else gnt=0, gnt_valid=0 -> IDLE.
//    - expiry: hold_cnt=MAX_HOLD-1 with req[gnt_idx] still 1. Same edge: grant
//      next winner from ptr, excluding current index; if no other req pending,
//      re-grant current requester, hold_cnt=0, ptr unchanged.
//  Current holder excluded from search only on expiry; on release its req is
//  already 0. Req changes of non-holders never disturb an active grant.
//  Simultaneous requests: ptr-relative order decides; after reset index 0 wins.
//  Requests dropped before grant are not remembered.
//  Wrap-around: ptr=7 scans 7,0,1..6; winner 7 -> ptr=0.
//  Reset mid-grant: gnt clears immediately (async); after release, IDLE, ptr=0.
//  Invariants: gnt one-hot or zero; gnt_valid == |gnt; gnt == decode(gnt_idx)
//  whenever gnt_valid=1.
// TESTING
//  1 Reset, req=8'h00 -> gnt=0, gnt_valid=0 for all cycles; IDLE.
//  2 req[3] held 3 cycles then dropped, MAX_HOLD=0 -> gnt[3]=1, gnt_idx=3 from
//    cycle after req, held 3 cycles, gnt=0 the cycle after drop; ptr=4.
//  3 All 8 req high, each holder drops req after 1 cycle of grant -> grants
//    0,1,2..7 back-to-back, no bubble, then gnt=0.
//  4 From ptr=6: req[1] and req[5] high simultaneously -> gnt_idx=1 first, then 5
//    (scan 6,7,0,1).
//  5 MAX_HOLD=4, req[2] and req[4] held high -> gnt[2] 4 cycles, gnt[4] 4 cycles,
//    alternating; only req[2] high -> gnt[2] continuous, hold_cnt restarts 0.
//  6 rst_n pulsed low mid-grant of idx 5 -> gnt=0 with no clock edge; after
//    release with req[5], req[7] high -> idx 5 granted (ptr=0).
//  Bench checks invariants every cycle via assertions.

Source files
------------

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot grant and an optional
// hold limit that forces a handoff after MAX_HOLD consecutive cycles.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:7] req,
  output logic [0:7] gnt,
  output logic [0:2] gnt_idx,
  output logic       gnt_valid
);

  localparam int unsigned N_REQ     = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [0:N_REQ-1]   gnt_q, gnt_d;
  logic [0:IDX_W-1]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;

  logic               cur_req_c;
  logic               at_limit_c;
  logic               hold_c;
  logic               expire_c;
  logic [0:N_REQ-1]   search_req_c;
  logic [IDX_W:0]     pick_c;
  logic               found_c;
  logic [IDX_W-1:0]   win_c;
  logic               new_grant_c;

  // First requester at or after start, wrapping; result is {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [0:N_REQ-1] r,
                                             input logic [IDX_W-1:0] start);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] i;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      i = start + IDX_W'(k);
      if (r[i]) res = {1'b1, i};
    end
    return res;
  endfunction

  always_comb begin
    cur_req_c  = req[gnt_idx_q];
    at_limit_c = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(HOLD_LAST));
    hold_c     = (state_q == GRANT) && cur_req_c && !at_limit_c;
    expire_c   = (state_q == GRANT) && cur_req_c && at_limit_c;

    // Holder only competes again on expiry when nobody else is waiting.
    search_req_c = req;
    if (expire_c) search_req_c[gnt_idx_q] = 1'b0;

    pick_c      = rr_pick(search_req_c, ptr_q);
    found_c     = pick_c[IDX_W];
    win_c       = pick_c[IDX_W-1:0];
    new_grant_c = found_c && !hold_c;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found_c) state_d = GRANT;
      GRANT:   if (!cur_req_c && !found_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the grant outputs, pointer and hold counter
  always_comb begin
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;

    if (new_grant_c) begin
      gnt_idx_d        = win_c;
      gnt_d            = '0;
      gnt_d[win_c]     = 1'b1;
      gnt_valid_d      = 1'b1;
      ptr_d            = win_c + IDX_W'(1);
      hold_cnt_d       = '0;
    end else if (hold_c) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end else if (expire_c) begin
      hold_cnt_d = '0;
    end else if (state_q == GRANT) begin
      gnt_d       = '0;
      gnt_valid_d = 1'b0;
      hold_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: unlimited-hold instance (a) and MAX_HOLD=4
// instance (b) share clock, reset and request inputs.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [0:7] req;
  logic [0:7] gnt_a, gnt_b;
  logic [0:2] gnt_idx_a, gnt_idx_b;
  logic       gnt_valid_a, gnt_valid_b;

  int checks   = 0;
  int failures = 0;

  rr_arbiter8 #(.MAX_HOLD(0), .CNT_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_a), .gnt_idx(gnt_idx_a), .gnt_valid(gnt_valid_a)
  );

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_b), .gnt_idx(gnt_idx_b), .gnt_valid(gnt_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         rst;
    bit         sel_b;
    logic [0:7] req;
    logic       ev;
    logic [2:0] ei;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string nm, input bit r, input bit sb,
                              input logic [0:7] rq, input logic ev, input logic [2:0] ei);
    vec_t v;
    v.name = nm; v.rst = r; v.sel_b = sb; v.req = rq; v.ev = ev; v.ei = ei;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input bit sb, input logic ev, input logic [2:0] ei);
    logic [0:7] eg, ag;
    logic       av;
    logic [2:0] ai;
    eg = '0;
    if (ev) eg[ei] = 1'b1;
    ag = sb ? gnt_b : gnt_a;
    av = sb ? gnt_valid_b : gnt_valid_a;
    ai = sb ? gnt_idx_b : gnt_idx_a;
    checks++;
    if (av !== ev || ag !== eg || (ev && ai !== ei)) begin
      failures++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b, expected gnt=%b idx=%0d valid=%b",
               nm, ag, ai, av, eg, ei, ev);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Structural invariants on both instances, every cycle
  always @(negedge clk) begin
    logic [0:7] dec;
    checks++;
    dec = '0;
    dec[gnt_idx_a] = 1'b1;
    assert ($onehot0(gnt_a) && (gnt_valid_a == |gnt_a) && (!gnt_valid_a || gnt_a == dec))
    else begin
      failures++;
      $display("FAIL inv_a: gnt=%b idx=%0d valid=%b", gnt_a, gnt_idx_a, gnt_valid_a);
    end
    checks++;
    dec = '0;
    dec[gnt_idx_b] = 1'b1;
    assert ($onehot0(gnt_b) && (gnt_valid_b == |gnt_b) && (!gnt_valid_b || gnt_b == dec))
    else begin
      failures++;
      $display("FAIL inv_b: gnt=%b idx=%0d valid=%b", gnt_b, gnt_idx_b, gnt_valid_b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;

    // Idle after reset
    add("idle0", 1, 0, 8'b0000_0000, 0, 0);
    add("idle1", 0, 0, 8'b0000_0000, 0, 0);
    add("idle2", 0, 0, 8'b0000_0000, 0, 0);
    // Single requester 3 held for three cycles, then dropped
    add("r3_c1", 0, 0, 8'b0001_0000, 1, 3);
    add("r3_c2", 0, 0, 8'b0001_0000, 1, 3);
    add("r3_c3", 0, 0, 8'b0001_0000, 1, 3);
    add("r3_rel", 0, 0, 8'b0000_0000, 0, 0);
    add("ptr4", 0, 0, 8'b1000_1000, 1, 4);
    add("ho_0", 0, 0, 8'b1000_0000, 1, 0);
    add("ho_idle", 0, 0, 8'b0000_0000, 0, 0);
    // All requesting, each drops after one granted cycle
    add("all_0", 1, 0, 8'b1111_1111, 1, 0);
    add("all_1", 0, 0, 8'b0111_1111, 1, 1);
    add("all_2", 0, 0, 8'b0011_1111, 1, 2);
    add("all_3", 0, 0, 8'b0001_1111, 1, 3);
    add("all_4", 0, 0, 8'b0000_1111, 1, 4);
    add("all_5", 0, 0, 8'b0000_0111, 1, 5);
    add("all_6", 0, 0, 8'b0000_0011, 1, 6);
    add("all_7", 0, 0, 8'b0000_0001, 1, 7);
    add("all_end", 0, 0, 8'b0000_0000, 0, 0);
    // Pointer at 6: scan 6,7,0,1 picks 1 before 5
    add("p6_set", 1, 0, 8'b0000_0100, 1, 5);
    add("p6_rel", 0, 0, 8'b0000_0000, 0, 0);
    add("p6_w1", 0, 0, 8'b0100_0100, 1, 1);
    add("p6_w5", 0, 0, 8'b0000_0100, 1, 5);
    add("p6_end", 0, 0, 8'b0000_0000, 0, 0);
    // Hold limit 4: requesters 2 and 4 alternate every four cycles
    add("mh_rst", 1, 1, 8'b0000_0000, 0, 0);
    for (int i = 0; i < 12; i++)
      add($sformatf("mh_alt%0d", i), 0, 1, 8'b0010_1000, 1, ((i / 4) % 2 == 1) ? 3'd4 : 3'd2);
    for (int i = 0; i < 8; i++)
      add($sformatf("mh_solo%0d", i), 0, 1, 8'b0010_0000, 1, 2);
    add("mh_rel", 0, 1, 8'b0000_0000, 0, 0);
    add("mh_ptr3", 0, 1, 8'b1000_1000, 1, 4);

    for (int n = 0; n < vecs.size(); n++) begin
      if (vecs[n].rst) do_reset();
      req = vecs[n].req;
      @(posedge clk);
      #1;
      check(vecs[n].name, vecs[n].sel_b, vecs[n].ev, vecs[n].ei);
    end

    // Async reset mid-grant of index 5, then 5 wins again from pointer 0
    do_reset();
    req = 8'b0000_0100;
    @(posedge clk); #1;
    check("ar_g5", 0, 1, 5);
    req = 8'b0000_0101;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ar_async_a", 0, 0, 0);
    check("ar_async_b", 1, 0, 0);
    @(posedge clk); #1;
    check("ar_held", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ar_w5", 0, 1, 5);
    req = 8'b0000_0001;
    @(posedge clk); #1;
    check("ar_w7", 0, 1, 7);
    req = 8'b0000_0000;
    @(posedge clk); #1;
    check("ar_end", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
